// File: rtl/rptr_empty_fwft.sv
// rptr_empty_fwft: read-side FIFO pointer/flags with a first-word-fall-through output register
module rptr_empty_fwft #(
    parameter int ADDRSIZE = 4,
    parameter int DATASIZE = 16
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [DATASIZE-1:0] rmem_data,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                arempty,
    output logic [ADDRSIZE:0]   rcount,
    output logic [DATASIZE-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready
);
    logic [ADDRSIZE:0] rbin, rbinnext, rbinnextp1, rgraynext, rgraynextp1, wbin_s;
    logic              rinc;
    assign rinc        = ~rempty & (~dout_valid | dout_ready);
    assign rbinnext    = rbin + (ADDRSIZE+1)'(rinc);
    assign rbinnextp1  = rbinnext + (ADDRSIZE+1)'(1);
    assign rgraynext   = (rbinnext >> 1) ^ rbinnext;
    assign rgraynextp1 = (rbinnextp1 >> 1) ^ rbinnextp1;
    assign raddr       = rbin[ADDRSIZE-1:0];
    // Gray-to-binary of the synchronized write pointer: each bit is the XOR of itself and all bits above
    always_comb begin
        wbin_s = '0;
        for (int i = 0; i <= ADDRSIZE; i++) wbin_s[i] = ^(rq2_wptr >> i);
    end
    // Read pointer and flags, all derived from the post-pop pointer so they stay registered
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin    <= '0;
            rptr    <= '0;
            rempty  <= 1'b1;
            arempty <= 1'b0;
            rcount  <= '0;
        end else begin
            rbin    <= rbinnext;
            rptr    <= rgraynext;
            rempty  <= rgraynext == rq2_wptr;
            arempty <= rgraynextp1 == rq2_wptr;
            rcount  <= wbin_s - rbinnext;
        end
    end
    // Output register: a pop refills it, an accept without refill empties it, otherwise it holds
    always_ff @(posedge rclk) begin
        if (rrst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (rinc) begin
            dout       <= rmem_data;
            dout_valid <= 1'b1;
        end else if (dout_valid & dout_ready) begin
            dout_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rptr_empty_fwft.sv
// tb_rptr_empty_fwft: scoreboard bench for the FWFT read-side pointer block
module tb_rptr_empty_fwft;
    localparam int AW = 4;
    localparam int DW = 16;
    logic          rclk = 1'b0;
    logic          rrst = 1'b1;
    logic [AW:0]   rq2_wptr = '0;
    logic [DW-1:0] rmem_data;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr;
    logic          rempty, arempty;
    logic [AW:0]   rcount;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic [DW-1:0] mem [16];
    logic [DW-1:0] exp_q [$];
    int            checks = 0, errors = 0;
    int            wtot = 0, m_rd = 0, m_count = 0;
    bit            m_empty = 1, m_aempty = 0, m_valid = 0;
    logic [DW-1:0] m_dout = '0;
    logic [DW-1:0] first_word;

    rptr_empty_fwft #(.ADDRSIZE(AW), .DATASIZE(DW)) dut (
        .rclk(rclk), .rrst(rrst), .rq2_wptr(rq2_wptr), .rmem_data(rmem_data),
        .raddr(raddr), .rptr(rptr), .rempty(rempty), .arempty(arempty),
        .rcount(rcount), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
    );

    assign rmem_data = mem[raddr];
    always #5 rclk = ~rclk;

    function automatic logic [AW:0] gray(input int b);
        logic [AW:0] x;
        x = b[AW:0];
        return (x >> 1) ^ x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic post(input int n);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = DW'($urandom);
            mem[wtot % 16] = d;
            exp_q.push_back(d);
            wtot++;
        end
        rq2_wptr = gray(wtot);
    endtask

    task automatic writer_reset();
        wtot = 0;
        exp_q.delete();
        rq2_wptr = '0;
    endtask

    task automatic step();
        bit pop;
        @(posedge rclk);
        if (rrst) begin
            m_rd = 0; m_count = 0; m_empty = 1; m_aempty = 0; m_valid = 0; m_dout = '0;
        end else begin
            pop = !m_empty && (!m_valid || dout_ready);
            if (pop) begin
                if (exp_q.size() > 0) m_dout = exp_q.pop_front();
                m_valid = 1;
            end else if (m_valid && dout_ready) begin
                m_valid = 0;
            end
            m_rd += int'(pop);
            m_count  = wtot - m_rd;
            m_empty  = m_count == 0;
            m_aempty = m_count == 1;
        end
        #1;
        chk("rempty", 32'(rempty), 32'(m_empty));
        chk("arempty", 32'(arempty), 32'(m_aempty));
        chk("rcount", 32'(rcount), m_count);
        chk("rcount_max", 32'(rcount <= 5'd16), 32'd1);
        chk("raddr", 32'(raddr), m_rd % 16);
        chk("rptr", 32'(rptr), 32'(gray(m_rd)));
        chk("dout_valid", 32'(dout_valid), 32'(m_valid));
        if (m_valid) chk("dout", 32'(dout), 32'(m_dout));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        step();
        step();
        chk("rst_rempty", 32'(rempty), 32'd1);
        chk("rst_arempty", 32'(arempty), 32'd0);
        chk("rst_rcount", 32'(rcount), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        rrst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("idle_rempty", 32'(rempty), 32'd1);
        chk("idle_valid", 32'(dout_valid), 32'd0);
        // one word, consumer stalled
        post(1);
        first_word = mem[0];
        step();
        chk("w1_rempty", 32'(rempty), 32'd0);
        chk("w1_arempty", 32'(arempty), 32'd1);
        chk("w1_rcount", 32'(rcount), 32'd1);
        step();
        chk("w1_valid", 32'(dout_valid), 32'd1);
        chk("w1_dout", 32'(dout), 32'(first_word));
        chk("w1_empty2", 32'(rempty), 32'd1);
        chk("w1_raddr", 32'(raddr), 32'd1);
        for (int i = 0; i < 3; i++) step();
        chk("w1_hold", 32'(dout), 32'(first_word));
        // reset while holding a word
        rrst = 1'b1;
        writer_reset();
        step();
        chk("midrst_valid", 32'(dout_valid), 32'd0);
        chk("midrst_rptr", 32'(rptr), 32'd0);
        rrst = 1'b0;
        step();
        // burst of a full memory, consumer always ready
        post(16);
        dout_ready = 1'b1;
        step();
        chk("full_rcount", 32'(rcount), 32'd16);
        for (int i = 0; i < 19; i++) step();
        chk("full_drained", 32'(rempty), 32'd1);
        chk("full_done", 32'(dout_valid), 32'd0);
        // backpressure pattern 1,0,0,1
        post(4);
        for (int i = 0; i < 16; i++) begin
            dout_ready = (i % 4 == 0) || (i % 4 == 3);
            step();
        end
        dout_ready = 1'b1;
        step();
        step();
        chk("bp_drained", 32'(rempty), 32'd1);
        // wrap: advance both pointers to 30, then cross the roll
        post(10);
        for (int i = 0; i < 14; i++) step();
        chk("pre_wrap_rptr", 32'(rptr), 32'(gray(30)));
        post(4);
        chk("wrap_wptr", 32'(rq2_wptr), 32'b00011);
        for (int i = 0; i < 8; i++) step();
        chk("wrap_rptr", 32'(rptr), 32'b00011);
        chk("wrap_empty", 32'(rempty), 32'd1);
        // random writer rate and consumer readiness
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 2) != 0 && wtot - m_rd < 16) post(1);
            dout_ready = $urandom_range(0, 3) != 0;
            step();
        end
        dout_ready = 1'b1;
        for (int i = 0; i < 40; i++) step();
        chk("final_empty", 32'(rempty), 32'd1);
        chk("final_queue", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
